merge_sort_parall_nbuf: RTL and testbench

Parametrised N-deep buffered memory channel between a producer and a consumer process of the merge-sort dataflow pipeline. Holds `BufferCount` independent dual-port RAM banks, hands whole banks from producer to consumer in strict FIFO order, and exposes occupancy and bank indices. Compared with the two-bank channel it generalises depth, grants a bank to the consumer when the channel is full, aligns read data with the bank that was addressed, and adds a synchronous flush.

---
 rtl/merge_sort_parall_nbuf.sv | 163 ++++++++++++++++
 tb/tb_merge_sort_parall_nbuf.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/merge_sort_parall_nbuf.sv
// N-bank ping-pong style channel: producer fills banks, consumer drains them in FIFO order.
// Read latency 1; flags/pointers update on the commit/release edge; access to unowned banks is dropped.
module merge_sort_parall_nbuf #(
  parameter int DataWidth    = 32,
  parameter int AddressRange = 32,
  parameter int AddressWidth = 5,
  parameter int BufferCount  = 4,
  parameter int IndexWidth   = 2,
  parameter int CountWidth   = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    i_ce,
  input  logic                    i_write,
  output logic                    i_full_n,
  input  logic                    i_ce0,
  input  logic                    i_we0,
  input  logic [AddressWidth-1:0] i_address0,
  input  logic [DataWidth-1:0]    i_d0,
  output logic [DataWidth-1:0]    i_q0,
  input  logic                    i_ce1,
  input  logic [AddressWidth-1:0] i_address1,
  output logic [DataWidth-1:0]    i_q1,
  input  logic                    t_ce,
  input  logic                    t_read,
  output logic                    t_empty_n,
  input  logic                    t_ce0,
  input  logic                    t_we0,
  input  logic [AddressWidth-1:0] t_address0,
  input  logic [DataWidth-1:0]    t_d0,
  output logic [DataWidth-1:0]    t_q0,
  input  logic                    t_ce1,
  input  logic [AddressWidth-1:0] t_address1,
  output logic [DataWidth-1:0]    t_q1,
  output logic [CountWidth-1:0]   count,
  output logic [IndexWidth-1:0]   i_index,
  output logic [IndexWidth-1:0]   t_index
);

  logic [IndexWidth-1:0] iptr_q, iptr_d, tptr_q, tptr_d;
  logic [IndexWidth-1:0] prev_iptr_q, prev_tptr_q;
  logic [CountWidth-1:0] count_q, count_d;
  logic                  full_n_q, full_n_d, empty_n_q, empty_n_d;
  logic                  push, pop;

  logic [BufferCount-1:0]  b_ce0, b_we0, b_ce1;
  logic [AddressWidth-1:0] b_a0 [BufferCount];
  logic [AddressWidth-1:0] b_a1 [BufferCount];
  logic [DataWidth-1:0]    b_d0 [BufferCount];
  logic [DataWidth-1:0]    mem_q [BufferCount][AddressRange];
  logic [DataWidth-1:0]    q0_q [BufferCount];
  logic [DataWidth-1:0]    q1_q [BufferCount];

  assign push = i_ce & i_write & full_n_q;
  assign pop  = t_ce & t_read & empty_n_q;

  function automatic logic [IndexWidth-1:0] next_ptr(input logic [IndexWidth-1:0] p);
    return (p == IndexWidth'(BufferCount - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    iptr_d    = push ? next_ptr(iptr_q) : iptr_q;
    tptr_d    = pop  ? next_ptr(tptr_q) : tptr_q;
    count_d   = count_q;
    full_n_d  = full_n_q;
    empty_n_d = empty_n_q;
    if (push && !pop) begin
      count_d   = count_q + 1'b1;
      empty_n_d = 1'b1;
      if (count_q == CountWidth'(BufferCount - 1)) full_n_d = 1'b0;
    end else if (pop && !push) begin
      count_d  = count_q - 1'b1;
      full_n_d = 1'b1;
      if (count_q == CountWidth'(1)) empty_n_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      iptr_q    <= '0;
      tptr_q    <= '0;
      count_q   <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
    end else begin
      iptr_q    <= iptr_d;
      tptr_q    <= tptr_d;
      count_q   <= count_d;
      full_n_q  <= full_n_d;
      empty_n_q <= empty_n_d;
    end
  end

  // Delayed pointers steer read data back from the bank addressed last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_iptr_q <= '0;
      prev_tptr_q <= '0;
    end else begin
      prev_iptr_q <= iptr_q;
      prev_tptr_q <= tptr_q;
    end
  end

  always_comb begin
    for (int k = 0; k < BufferCount; k++) begin
      b_ce0[k] = 1'b0;
      b_we0[k] = 1'b0;
      b_ce1[k] = 1'b0;
      b_a0[k]  = '0;
      b_a1[k]  = '0;
      b_d0[k]  = '0;
      if (iptr_q == IndexWidth'(k) && full_n_q) begin
        b_ce0[k] = i_ce0;
        b_we0[k] = i_we0;
        b_ce1[k] = i_ce1;
        b_a0[k]  = i_address0;
        b_a1[k]  = i_address1;
        b_d0[k]  = i_d0;
      end else if (tptr_q == IndexWidth'(k) && empty_n_q) begin
        b_ce0[k] = t_ce0;
        b_we0[k] = t_we0;
        b_ce1[k] = t_ce1;
        b_a0[k]  = t_address0;
        b_a1[k]  = t_address1;
        b_d0[k]  = t_d0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < BufferCount; k++) begin
      if (b_ce0[k] && b_we0[k]) mem_q[k][b_a0[k]] <= b_d0[k];
    end
  end

  // Read-first: q samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < BufferCount; k++) begin
        q0_q[k] <= '0;
        q1_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < BufferCount; k++) begin
        if (b_ce0[k]) q0_q[k] <= mem_q[k][b_a0[k]];
        if (b_ce1[k]) q1_q[k] <= mem_q[k][b_a1[k]];
      end
    end
  end

  assign i_q0      = q0_q[prev_iptr_q];
  assign i_q1      = q1_q[prev_iptr_q];
  assign t_q0      = q0_q[prev_tptr_q];
  assign t_q1      = q1_q[prev_tptr_q];
  assign i_full_n  = full_n_q;
  assign t_empty_n = empty_n_q;
  assign count     = count_q;
  assign i_index   = iptr_q;
  assign t_index   = tptr_q;

endmodule

// File: tb/tb_merge_sort_parall_nbuf.sv
// Directed bench for the N-bank channel: fill/drain, overlap, ownership, read-first, flush and reset.
module tb_merge_sort_parall_nbuf;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        i_ce, i_write, i_full_n;
  logic        i_ce0, i_we0, i_ce1;
  logic [4:0]  i_address0, i_address1;
  logic [31:0] i_d0, i_q0, i_q1;
  logic        t_ce, t_read, t_empty_n;
  logic        t_ce0, t_we0, t_ce1;
  logic [4:0]  t_address0, t_address1;
  logic [31:0] t_d0, t_q0, t_q1;
  logic [2:0]  cnt;
  logic [1:0]  i_index, t_index;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  merge_sort_parall_nbuf dut (
    .clk(clk), .reset(reset), .flush(flush),
    .i_ce(i_ce), .i_write(i_write), .i_full_n(i_full_n),
    .i_ce0(i_ce0), .i_we0(i_we0), .i_address0(i_address0), .i_d0(i_d0), .i_q0(i_q0),
    .i_ce1(i_ce1), .i_address1(i_address1), .i_q1(i_q1),
    .t_ce(t_ce), .t_read(t_read), .t_empty_n(t_empty_n),
    .t_ce0(t_ce0), .t_we0(t_we0), .t_address0(t_address0), .t_d0(t_d0), .t_q0(t_q0),
    .t_ce1(t_ce1), .t_address1(t_address1), .t_q1(t_q1),
    .count(cnt), .i_index(i_index), .t_index(t_index)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 0; flush = 0;
    i_ce = 0; i_write = 0; i_ce0 = 0; i_we0 = 0; i_ce1 = 0;
    i_address0 = 0; i_address1 = 0; i_d0 = 0;
    t_ce = 0; t_read = 0; t_ce0 = 0; t_we0 = 0; t_ce1 = 0;
    t_address0 = 0; t_address1 = 0; t_d0 = 0;
  endtask

  // Inputs are driven 1 time unit after an edge; outputs sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic push_cycle();
    i_ce = 1; i_write = 1;
  endtask

  initial begin
    idle();
    #1;
    reset = 1;
    tick();
    reset = 1;
    tick();
    chk("rst_full_n", i_full_n, 1);
    chk("rst_empty_n", t_empty_n, 0);
    chk("rst_count", cnt, 0);
    chk("rst_i_index", i_index, 0);
    chk("rst_t_index", t_index, 0);
    chk("rst_i_q0", i_q0, 0);
    chk("rst_t_q1", t_q1, 0);

    // Fill all four banks, writing 0x10+k at address 3 in the commit cycle.
    for (int k = 0; k < 4; k++) begin
      i_ce0 = 1; i_we0 = 1; i_address0 = 3; i_d0 = 32'h10 + k;
      push_cycle();
      tick();
      chk("fill_count", cnt, k + 1);
      chk("fill_empty_n", t_empty_n, 1);
    end
    chk("full_flag", i_full_n, 0);
    chk("full_i_index", i_index, 0);

    // Push while full is ignored; producer write into the consumer-owned bank is dropped.
    push_cycle();
    i_ce0 = 1; i_we0 = 1; i_address0 = 3; i_d0 = 32'hDEAD;
    tick();
    chk("full_push_count", cnt, 4);
    chk("full_push_index", i_index, 0);

    // Consumer owns bank 0 while full: write 0xBEEF at address 4 and read it back.
    t_ce0 = 1; t_we0 = 1; t_address0 = 4; t_d0 = 32'hBEEF;
    tick();
    t_ce0 = 1; t_address0 = 4;
    tick();
    chk("cons_write_beef", t_q0, 32'hBEEF);

    // Read-first on both ports: old 0x22 at address 5, then write 0x77 while reading.
    t_ce0 = 1; t_we0 = 1; t_address0 = 5; t_d0 = 32'h22;
    tick();
    t_ce0 = 1; t_we0 = 1; t_address0 = 5; t_d0 = 32'h77;
    t_ce1 = 1; t_address1 = 5;
    tick();
    chk("rf_port1_old", t_q1, 32'h22);
    chk("rf_port0_old", t_q0, 32'h22);
    t_ce0 = 1; t_address0 = 5;
    tick();
    chk("rf_new_data", t_q0, 32'h77);

    // Drain: read address 3 in the release cycle; data must come from the released bank.
    for (int k = 0; k < 4; k++) begin
      t_ce0 = 1; t_address0 = 3;
      t_ce = 1; t_read = 1;
      tick();
      chk("drain_q0", t_q0, 32'h10 + k);
      chk("drain_count", cnt, 3 - k);
      chk("drain_t_index", t_index, (k + 1) % 4);
      chk("drain_full_n", i_full_n, 1);
    end
    chk("drain_empty_n", t_empty_n, 0);

    // Bring occupancy to 2, then overlap push and pop for six cycles.
    push_cycle(); tick();
    push_cycle(); tick();
    chk("ov_start_count", cnt, 2);
    for (int j = 0; j < 6; j++) begin
      push_cycle();
      t_ce = 1; t_read = 1;
      tick();
      chk("ov_count", cnt, 2);
      chk("ov_i_index", i_index, (3 + j) % 4);
      chk("ov_t_index", t_index, (1 + j) % 4);
      chk("ov_full_n", i_full_n, 1);
      chk("ov_empty_n", t_empty_n, 1);
    end

    // Now iptr=0, tptr=2, count=2: push once writing 0x55 at bank 0 address 7.
    i_ce0 = 1; i_we0 = 1; i_address0 = 7; i_d0 = 32'h55;
    push_cycle();
    tick();
    chk("pre_flush_count", cnt, 3);

    flush = 1;
    push_cycle();
    t_ce = 1; t_read = 1;
    tick();
    chk("fl_count", cnt, 0);
    chk("fl_empty_n", t_empty_n, 0);
    chk("fl_full_n", i_full_n, 1);
    chk("fl_i_index", i_index, 0);
    chk("fl_t_index", t_index, 0);
    i_ce0 = 1; i_address0 = 7;
    i_ce1 = 1; i_address1 = 7;
    tick();
    chk("fl_ram_kept_q0", i_q0, 32'h55);
    chk("fl_ram_kept_q1", i_q1, 32'h55);

    // Same scenario with reset: count 3, then reset with push/pop and a read pending.
    for (int k = 0; k < 3; k++) begin
      push_cycle();
      tick();
    end
    chk("pre_rst_count", cnt, 3);
    reset = 1;
    push_cycle();
    t_ce = 1; t_read = 1;
    i_ce0 = 1; i_address0 = 7;
    tick();
    chk("rs_count", cnt, 0);
    chk("rs_empty_n", t_empty_n, 0);
    chk("rs_full_n", i_full_n, 1);
    chk("rs_i_index", i_index, 0);
    chk("rs_t_index", t_index, 0);
    chk("rs_i_q0", i_q0, 0);
    chk("rs_i_q1", i_q1, 0);
    chk("rs_t_q0", t_q0, 0);
    chk("rs_t_q1", t_q1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
